// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction prefetch stage with a
// DEPTH-entry output buffer and redirect flush of in-flight fetches.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [31:0] fetch_pc;

  ent_t        fifo [DEPTH];
  ptr_t        head;
  ptr_t        tail;
  cnt_t        occ;

  logic [29:0] pcq [DEPTH];
  ptr_t        pcq_wr;
  ptr_t        pcq_rd;

  cnt_t        inflight;
  cnt_t        drop;

  logic        req_fire;
  logic        resp_fire;
  logic        resp_drop;
  logic        push;
  logic        pop;
  logic [CW:0] credit_used;

  // Credit check, handshakes and head-of-buffer outputs
  always_comb begin
    credit_used   = {1'b0, inflight} + {1'b0, occ};
    mem_req_valid = reset && !redirect
                    && (credit_used < DEPTH_C);
    mem_req_addr  = fetch_pc;
    req_fire      = mem_req_valid && mem_req_ready;
    resp_fire     = mem_resp_valid;
    resp_drop     = redirect || (drop != '0);
    push          = resp_fire && !resp_drop;
    out_valid     = (occ != '0);
    pop           = out_valid && out_ready;
    out_instr     = '0;
    out_pc        = '0;
    if (out_valid) begin
      out_instr = fifo[head].instr;
      out_pc    = {fifo[head].pc, 2'b00};
    end
  end

  // Fetch PC and the pointers of the per-request PC queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (req_fire) begin
        pcq_wr <= pcq_wr + ptr_t'(1);
      end
      if (resp_fire) begin
        pcq_rd <= pcq_rd + ptr_t'(1);
      end
    end
  end

  // PC of each accepted request, consumed in response order
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq[pcq_wr] <= fetch_pc[31:2];
    end
  end

  // Outstanding-request and stale-response counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + cnt_t'(req_fire)
                  - cnt_t'(resp_fire);
      if (redirect) begin
        drop <= inflight - cnt_t'(resp_fire);
      end else if (resp_fire && (drop != '0)) begin
        drop <= drop - cnt_t'(1);
      end
    end
  end

  // Output buffer pointers and occupancy; redirect empties it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (redirect) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        tail <= tail + ptr_t'(1);
      end
      if (pop) begin
        head <= head + ptr_t'(1);
      end
      occ <= occ + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Output buffer storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail] <= '{pc: pcq[pcq_rd], instr: mem_resp_data};
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: scoreboard bench with an in-order memory model,
// directed latency/backpressure/redirect/reset cases and a random run.
module tb_if_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // memory contents: a fixed scramble of the word address
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    int          epoch;
  } exp_t;

  mreq_t       rq[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          epoch = 0;
  int          req_count = 0;
  int          pop_count = 0;
  logic [31:0] exp_addr = RPC;
  logic [31:0] redir_tgt = '0;
  bit          redir_seen = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;
  int          resp_pct = 100;
  logic [31:0] pv_addr = '0;
  bit          pv_hold = 0;

  // Memory model: drives after the edge, observes handshakes mid-cycle.
  // Every accepted request pushes its expected output into exp_q.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (redir_seen) begin
        epoch++;
        exp_addr   = redir_tgt & 32'hFFFF_FFFC;
        redir_seen = 0;
      end
      if (!reset) begin
        rq.delete();
        epoch++;
        exp_addr   = RPC;
        redir_seen = 0;
      end
      mem_req_ready = ($urandom_range(99) < ready_pct);
      if (reset && rq.size() > 0 && rq[0].due <= cyc
          && $urandom_range(99) < resp_pct) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = word_at(rq[0].addr);
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
      end
      @(negedge clk);
      if (mem_resp_valid && rq.size() > 0) begin
        void'(rq.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, exp_addr);
        rq.push_back('{mem_req_addr,
                       cyc + int'($urandom_range(lat_max, lat_min))});
        exp_q.push_back('{exp_addr, epoch});
        exp_addr += 32'd4;
        req_count++;
      end
      if (redirect) begin
        redir_seen = 1;
        redir_tgt  = redirect_pc;
      end
    end
  end

  // Monitor: request hold rule and output scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset && pv_hold && !redirect) begin
        check("req_hold_valid", 32'(mem_req_valid), 32'd1);
        check("req_hold_addr", mem_req_addr, pv_addr);
      end
      pv_hold = reset && mem_req_valid && !mem_req_ready;
      pv_addr = mem_req_addr;
      if (reset && out_valid && out_ready) begin
        while (exp_q.size() > 0 && exp_q[0].epoch != epoch) begin
          void'(exp_q.pop_front());
        end
        pop_count++;
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("out_pc", out_pc, exp_q[0].pc);
          check("out_instr", out_instr, word_at(exp_q[0].pc));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_mem(input int lmin, input int lmax,
                         input int rp, input int sp);
    lat_min   = lmin;
    lat_max   = lmax;
    ready_pct = rp;
    resp_pct  = sp;
  endtask

  // Stimulus
  initial begin
    int          r0;
    int          p0;
    int          waited;
    logic [31:0] acc[$];

    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    set_mem(1, 1, 100, 100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);

    // release, 1-cycle memory, consumer always ready
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("first_req_valid", 32'(mem_req_valid), 32'd1);
    check("first_req_addr", mem_req_addr, RPC);
    @(negedge clk);
    check("lat_c1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_out_valid", 32'(out_valid), 32'd1);
    check("first_out_pc", out_pc, RPC);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_pc", out_pc, RPC + 32'(4 * (i + 1)));
    end

    // stall the consumer until the buffer fills
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("full_req_valid", 32'(mem_req_valid), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);

    // asynchronous reset with a full buffer
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_req_valid", 32'(mem_req_valid), 32'd0);
    check("async_out_instr", out_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    r0    = req_count;
    repeat (12) @(negedge clk);
    check("bp_req_count", 32'(req_count - r0), 32'(DEPTH));
    check("bp_req_valid", 32'(mem_req_valid), 32'd0);
    check("bp_head_pc", out_pc, RPC);

    // single pop frees one credit
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("credit_req_valid", 32'(mem_req_valid), 32'd1);
    check("credit_req_addr", mem_req_addr, RPC + 32'h10);
    repeat (4) @(negedge clk);
    check("credit_req_count", 32'(req_count - r0), 32'(DEPTH + 1));

    // redirect together with a response and a pop, wrapping PC
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    check("redir_resp_same", 32'(mem_resp_valid), 32'd1);
    check("redir_pop_same", 32'(out_valid), 32'd1);
    check("redir_req_low", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("redir_flushed", 32'(out_valid), 32'd0);
    acc.delete();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (mem_req_valid && mem_req_ready) acc.push_back(mem_req_addr);
    end
    check("wrap_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      check("wrap_a0", acc[0], 32'hFFFF_FFF8);
      check("wrap_a1", acc[1], 32'hFFFF_FFFC);
      check("wrap_a2", acc[2], 32'h0000_0000);
    end

    // redirect with 3-cycle memory latency
    @(posedge clk);
    #1;
    set_mem(3, 3, 100, 100);
    repeat (10) @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4002;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("r3_req_valid", 32'(mem_req_valid), 32'd1);
    check("r3_req_addr", mem_req_addr, 32'h0000_4000);
    check("r3_out_valid", 32'(out_valid), 32'd0);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("r3_out_arrived", 32'(out_valid), 32'd1);
    check("r3_first_pc", out_pc, 32'h0000_4000);

    // random traffic
    @(posedge clk);
    #1;
    set_mem(1, 4, 70, 75);
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(99) < 60);
      redirect  = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else
        redirect_pc = $urandom;
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;

    // drain with an ideal memory: full throughput must resume
    set_mem(1, 1, 100, 100);
    out_ready = 1'b1;
    p0 = pop_count;
    repeat (40) @(negedge clk);
    check("drain_throughput", 32'(pop_count - p0 >= 30), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
